if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue.sv | 191 +++++++++++++++++++
 tb/tb_if_id_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
// ----------------------------------------------------------------------------
// Purpose:
//    Instruction queue between the fetch (IF) and decode (ID) stages. Fetch
//    pushes {instruction, PC}. Decode pops the head entry. The head entry is
//    presented with the fields decode needs: the instruction word, PC + 4,
//    the 16-bit immediate and the rs/rt/rd register specifiers. While the
//    queue is empty, the head shows NOP_INSTR and a PC + 4 of zero. A flush
//    from branch/jump resolution discards every entry on the next edge.
//
// Parameters:
//    DEPTH      - number of entries (power of two, >= 2)
//    NOP_INSTR  - instruction word presented while the queue is empty
//
// Ports:
//    clk          in   single clock, rising edge
//    reset        in   asynchronous active-high reset
//    in_valid     in   fetch offers an instruction this cycle
//    in_instr     in   fetched instruction word
//    in_pc        in   address of in_instr
//    in_ready     out  queue accepts a push this cycle (count != DEPTH)
//    flush        in   synchronous discard of all entries
//    out_ready    in   decode consumes the head entry this cycle
//    out_valid    out  head entry is valid (count != 0)
//    out_instr    out  head instruction word
//    out_pc_plus4 out  head PC + 4 (32-bit wrap)
//    out_imm16    out  out_instr[15:0]
//    out_rs       out  out_instr[25:21]
//    out_rt       out  out_instr[20:16]
//    out_rd       out  out_instr[15:11]
//    count        out  number of valid entries
//
// Every output comes directly from a register or is a bit slice of one. The
// head word and the flags are computed one cycle ahead from the next-state
// values. This keeps in_ready free of any combinational path from out_ready.
// ----------------------------------------------------------------------------
module if_id_queue #(
   parameter int          DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [31:0]                in_instr,
   input  logic [31:0]                in_pc,
   output logic                       in_ready,
   input  logic                       flush,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [31:0]                out_instr,
   output logic [31:0]                out_pc_plus4,
   output logic [15:0]                out_imm16,
   output logic [4:0]                 out_rs,
   output logic [4:0]                 out_rt,
   output logic [4:0]                 out_rd,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] EMPTY_CNT = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
   localparam logic [PTR_W-1:0] ZERO_PTR  = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);

   // The entry storage is not reset. Entries are only readable while count
   // marks them valid, and the empty head is forced to NOP_INSTR.
   logic [31:0]      instrMem_r [DEPTH];
   logic [31:0]      pcPlus4Mem_r [DEPTH];

   logic [PTR_W-1:0] rdPtr_r;
   logic [PTR_W-1:0] wrPtr_r;
   logic [CNT_W-1:0] count_r;
   logic             inReady_r;
   logic             outValid_r;
   logic [31:0]      headInstr_r;
   logic [31:0]      headPcPlus4_r;

   logic             push_s;
   logic             pop_s;
   logic [31:0]      inPcPlus4_s;
   logic [PTR_W-1:0] rdPtrNext_s;
   logic [PTR_W-1:0] wrPtrNext_s;
   logic [CNT_W-1:0] countNext_s;
   logic [31:0]      headInstrNext_s;
   logic [31:0]      headPcPlus4Next_s;

   // Handshakes use the registered flags, so neither depends on the other side's ready.
   always_comb begin
      push_s      = in_valid & inReady_r;
      pop_s       = outValid_r & out_ready;
      inPcPlus4_s = in_pc + 32'd4;
   end

   // Next pointers and count. Flush wins over any push or pop in the same cycle.
   always_comb begin
      rdPtrNext_s = rdPtr_r;
      wrPtrNext_s = wrPtr_r;
      countNext_s = count_r;
      if (flush) begin
         rdPtrNext_s = ZERO_PTR;
         wrPtrNext_s = ZERO_PTR;
         countNext_s = EMPTY_CNT;
      end else begin
         if (push_s) begin
            wrPtrNext_s = wrPtr_r + ONE_PTR;
         end else begin
            wrPtrNext_s = wrPtr_r;
         end
         if (pop_s) begin
            rdPtrNext_s = rdPtr_r + ONE_PTR;
         end else begin
            rdPtrNext_s = rdPtr_r;
         end
         case ({push_s, pop_s})
            2'b10:   countNext_s = count_r + ONE_CNT;
            2'b01:   countNext_s = count_r - ONE_CNT;
            default: countNext_s = count_r;
         endcase
      end
   end

   // Head entry for the next cycle. The entry being written this cycle lands
   // at the head when the next read pointer equals the current write pointer
   // and a push is under way. That happens on a push into an empty queue, or
   // on a push+pop with a single entry. Storage is not yet updated in either
   // case, so the incoming values are forwarded into the head register.
   always_comb begin
      headInstrNext_s   = NOP_INSTR;
      headPcPlus4Next_s = 32'h00000000;
      if (countNext_s == EMPTY_CNT) begin
         headInstrNext_s   = NOP_INSTR;
         headPcPlus4Next_s = 32'h00000000;
      end else if (push_s && (wrPtr_r == rdPtrNext_s)) begin
         headInstrNext_s   = in_instr;
         headPcPlus4Next_s = inPcPlus4_s;
      end else begin
         headInstrNext_s   = instrMem_r[rdPtrNext_s];
         headPcPlus4Next_s = pcPlus4Mem_r[rdPtrNext_s];
      end
   end

   // Entry storage write. A push that coincides with a flush is dropped.
   always_ff @(posedge clk) begin
      if (push_s && !flush) begin
         instrMem_r[wrPtr_r]   <= in_instr;
         pcPlus4Mem_r[wrPtr_r] <= inPcPlus4_s;
      end else begin
         instrMem_r[wrPtr_r]   <= instrMem_r[wrPtr_r];
         pcPlus4Mem_r[wrPtr_r] <= pcPlus4Mem_r[wrPtr_r];
      end
   end

   // Control state and registered outputs. Reset clears them immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdPtr_r       <= ZERO_PTR;
         wrPtr_r       <= ZERO_PTR;
         count_r       <= EMPTY_CNT;
         inReady_r     <= 1'b1;
         outValid_r    <= 1'b0;
         headInstr_r   <= NOP_INSTR;
         headPcPlus4_r <= 32'h00000000;
      end else begin
         rdPtr_r       <= rdPtrNext_s;
         wrPtr_r       <= wrPtrNext_s;
         count_r       <= countNext_s;
         inReady_r     <= (countNext_s != FULL_CNT);
         outValid_r    <= (countNext_s != EMPTY_CNT);
         headInstr_r   <= headInstrNext_s;
         headPcPlus4_r <= headPcPlus4Next_s;
      end
   end

   // Output ports: registers and bit slices of the head instruction register.
   always_comb begin
      in_ready     = inReady_r;
      out_valid    = outValid_r;
      count        = count_r;
      out_instr    = headInstr_r;
      out_pc_plus4 = headPcPlus4_r;
      out_imm16    = headInstr_r[15:0];
      out_rs       = headInstr_r[25:21];
      out_rt       = headInstr_r[20:16];
      out_rd       = headInstr_r[15:11];
   end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        in_ready;
   logic        flush;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc_plus4;
   logic [15:0] out_imm16;
   logic [4:0]  out_rs;
   logic [4:0]  out_rt;
   logic [4:0]  out_rd;
   logic [1:0]  count;

   int nTests = 0;
   int nFail  = 0;

   if_id_queue #(.DEPTH(2), .NOP_INSTR(32'h00000000)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
      .in_pc(in_pc), .in_ready(in_ready), .flush(flush), .out_ready(out_ready),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc_plus4(out_pc_plus4),
      .out_imm16(out_imm16), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
      .count(count)
   );

   always #5 clk = ~clk;

   // advance one rising edge, then settle 1 time unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      nTests++; if (count !== 2'd0) begin nFail++; $display("FAIL reset_count got %0d exp 0", count); end
      nTests++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      nTests++; if (in_ready !== 1'b1) begin nFail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      nTests++; if (out_instr !== 32'h0) begin nFail++; $display("FAIL reset_out_instr got %h exp 00000000", out_instr); end
      nTests++; if (out_pc_plus4 !== 32'h0) begin nFail++; $display("FAIL reset_pc4 got %h exp 00000000", out_pc_plus4); end
      @(negedge clk);
      reset = 1'b0;
      step();
   endtask

   task automatic test_push_decode();
      in_valid = 1'b1; in_instr = 32'h2008FFFF; in_pc = 32'h00400000; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      nTests++; if (out_valid !== 1'b1) begin nFail++; $display("FAIL decode_valid got %b exp 1", out_valid); end
      nTests++; if (out_imm16 !== 16'hFFFF) begin nFail++; $display("FAIL decode_imm16 got %h exp ffff", out_imm16); end
      nTests++; if (out_rt !== 5'd8) begin nFail++; $display("FAIL decode_rt got %0d exp 8", out_rt); end
      nTests++; if (out_rs !== 5'd0) begin nFail++; $display("FAIL decode_rs got %0d exp 0", out_rs); end
      nTests++; if (out_rd !== 5'd31) begin nFail++; $display("FAIL decode_rd got %0d exp 31", out_rd); end
      nTests++; if (out_pc_plus4 !== 32'h00400004) begin nFail++; $display("FAIL decode_pc4 got %h exp 00400004", out_pc_plus4); end
      nTests++; if (count !== 2'd1) begin nFail++; $display("FAIL decode_count got %0d exp 1", count); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      nTests++; if (count !== 2'd0) begin nFail++; $display("FAIL decode_drain_count got %0d exp 0", count); end
      nTests++; if (out_instr !== 32'h0) begin nFail++; $display("FAIL decode_drain_nop got %h exp 00000000", out_instr); end
   endtask

   task automatic test_fill_full();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h11111111; in_pc = 32'h00000100;
      step();
      in_instr = 32'h22222222; in_pc = 32'h00000104;
      step();
      nTests++; if (count !== 2'd2) begin nFail++; $display("FAIL full_count got %0d exp 2", count); end
      nTests++; if (in_ready !== 1'b0) begin nFail++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
      in_instr = 32'h33333333; in_pc = 32'h00000108;
      step();
      in_valid = 1'b0;
      nTests++; if (count !== 2'd2) begin nFail++; $display("FAIL full_third_count got %0d exp 2", count); end
      nTests++; if (out_instr !== 32'h11111111) begin nFail++; $display("FAIL stall_head got %h exp 11111111", out_instr); end
      out_ready = 1'b1;
      step();
      nTests++; if (out_instr !== 32'h22222222) begin nFail++; $display("FAIL full_second_head got %h exp 22222222", out_instr); end
      nTests++; if (out_pc_plus4 !== 32'h00000108) begin nFail++; $display("FAIL full_second_pc4 got %h exp 00000108", out_pc_plus4); end
      nTests++; if (count !== 2'd1) begin nFail++; $display("FAIL full_pop_count got %0d exp 1", count); end
      nTests++; if (in_ready !== 1'b1) begin nFail++; $display("FAIL full_ready_rise got %b exp 1", in_ready); end
      step();
      out_ready = 1'b0;
      nTests++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL full_third_dropped got %b exp 0", out_valid); end
   endtask

   task automatic test_push_pop();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h44444444; in_pc = 32'h00000200;
      step();
      in_instr = 32'h55555555; in_pc = 32'h00000204; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      nTests++; if (count !== 2'd1) begin nFail++; $display("FAIL pushpop_count got %0d exp 1", count); end
      nTests++; if (out_instr !== 32'h55555555) begin nFail++; $display("FAIL pushpop_head got %h exp 55555555", out_instr); end
      nTests++; if (out_pc_plus4 !== 32'h00000208) begin nFail++; $display("FAIL pushpop_pc4 got %h exp 00000208", out_pc_plus4); end
      step();
      out_ready = 1'b0;
      nTests++; if (count !== 2'd0) begin nFail++; $display("FAIL pushpop_drain got %0d exp 0", count); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h66666666; in_pc = 32'h00000300;
      step();
      in_instr = 32'h77777777; in_pc = 32'h00000304;
      step();
      flush = 1'b1; in_instr = 32'h88888888; in_pc = 32'h00000308; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      nTests++; if (count !== 2'd0) begin nFail++; $display("FAIL flush_count got %0d exp 0", count); end
      nTests++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL flush_valid got %b exp 0", out_valid); end
      nTests++; if (out_instr !== 32'h0) begin nFail++; $display("FAIL flush_instr got %h exp 00000000", out_instr); end
      nTests++; if (in_ready !== 1'b1) begin nFail++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
      nTests++; if (out_pc_plus4 !== 32'h0) begin nFail++; $display("FAIL flush_pc4 got %h exp 00000000", out_pc_plus4); end
      in_valid = 1'b1; in_instr = 32'h99999999; in_pc = 32'h00000400;
      step();
      in_valid = 1'b0;
      nTests++; if (out_instr !== 32'h99999999) begin nFail++; $display("FAIL post_flush_head got %h exp 99999999", out_instr); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_pc_wrap();
      in_valid = 1'b1; in_instr = 32'h0000ABCD; in_pc = 32'hFFFFFFFC;
      step();
      in_valid = 1'b0;
      nTests++; if (out_valid !== 1'b1) begin nFail++; $display("FAIL wrap_valid got %b exp 1", out_valid); end
      nTests++; if (out_pc_plus4 !== 32'h00000000) begin nFail++; $display("FAIL wrap_pc4 got %h exp 00000000", out_pc_plus4); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [5];
      words[0] = 32'hA0000001; words[1] = 32'hA0000002; words[2] = 32'hA0000003;
      words[3] = 32'hA0000004; words[4] = 32'hA0000005;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_instr = words[k]; in_pc = 32'h00001000 + 32'(k * 4);
         step();
         nTests++; if (out_instr !== words[k] || count !== 2'd1) begin
            nFail++; $display("FAIL stream_%0d got %h/%0d exp %h/1", k, out_instr, count, words[k]);
         end
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      nTests++; if (count !== 2'd0) begin nFail++; $display("FAIL stream_drain got %0d exp 0", count); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'hB0000001; in_pc = 32'h00002000;
      step();
      in_instr = 32'hB0000002;
      step();
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      nTests++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL areset_valid got %b exp 0", out_valid); end
      nTests++; if (count !== 2'd0) begin nFail++; $display("FAIL areset_count got %0d exp 0", count); end
      nTests++; if (in_ready !== 1'b1) begin nFail++; $display("FAIL areset_in_ready got %b exp 1", in_ready); end
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b1; in_instr = 32'hC0000001; in_pc = 32'h00003000;
      step();
      in_valid = 1'b0;
      nTests++; if (out_valid !== 1'b1 || out_instr !== 32'hC0000001) begin
         nFail++; $display("FAIL first_push_after_reset got %b/%h exp 1/c0000001", out_valid, out_instr);
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
      flush = 1'b0; out_ready = 1'b0;
      test_reset();
      test_push_decode();
      test_fill_full();
      test_push_pop();
      test_flush();
      test_pc_wrap();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
